// File: rtl/cache_bus_req_queue.sv
// rtl/cache_bus_req_queue.sv - buffers L1 controller bus actions and issues them as single-beat bus transactions
//
// Purpose:
//   Accepts per-access bus actions from the L1 cache controller into a small
//   circular queue and replays them, in acceptance order, as single-beat
//   transactions on a valid/ready bus. RW_OUT expands into a write-back beat
//   to the victim line followed by a line-fill read of the accessed line.
//   Running read/write beat counts feed the end-of-run statistics.
//
// Ports:
//   clk             in   sole clock, rising edge
//   rst             in   synchronous active-high reset
//   in_valid        in   controller presents an action
//   in_ready        out  queue can accept (count < DEPTH)
//   in_op           in   action: READ_OUT=0, WRITE_OUT=1, RW_OUT=2, NOP=3
//   in_addr         in   accessed line address
//   in_victim_addr  in   evicted dirty line address (RW_OUT only)
//   bus_valid       out  bus beat presented (registered)
//   bus_ready       in   bus accepts beat
//   bus_write       out  1 = write-back beat, 0 = read/fill beat (registered)
//   bus_addr        out  beat address (registered)
//   busy            out  queue non-empty or beat in flight
//   rd_count        out  accepted read beats, wraps modulo 2^32
//   wr_count        out  accepted write beats, wraps modulo 2^32

module cache_bus_req_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_victim_addr,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RW    = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE_WR = 2'd1,
        S_ISSUE_RD = 2'd2
    } state_t;

    // Queue storage
    logic [1:0]        r_q_op     [DEPTH];
    logic [ADDR_W-1:0] r_q_addr   [DEPTH];
    logic [ADDR_W-1:0] r_q_victim [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_bus_valid;
    logic              r_bus_write;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              w_bus_valid_nxt;
    logic              w_bus_write_nxt;
    logic [ADDR_W-1:0] w_bus_addr_nxt;

    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_hs;
    logic              w_load;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [PTR_W-1:0]  w_ld_ptr;
    logic [1:0]        w_head_op;
    logic [ADDR_W-1:0] w_head_addr;
    logic [1:0]        w_ld_op;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [ADDR_W-1:0] w_ld_victim;
    logic              w_more_queued;

    assign w_in_ready = (r_count < CNT_W'(DEPTH));
    assign w_accept   = in_valid && w_in_ready;
    // NOP needs a handshake slot but never occupies the queue
    assign w_push     = w_accept && (in_op != OP_NOP);
    assign w_hs       = r_bus_valid && bus_ready;

    assign w_next_ptr  = r_rd_ptr + PTR_W'(1);
    assign w_head_op   = r_q_op[r_rd_ptr];
    assign w_head_addr = r_q_addr[r_rd_ptr];

    // From IDLE the head is loaded; after a pop the entry behind it is loaded
    assign w_ld_ptr    = (r_state == S_IDLE) ? r_rd_ptr : w_next_ptr;
    assign w_ld_op     = r_q_op[w_ld_ptr];
    assign w_ld_addr   = r_q_addr[w_ld_ptr];
    assign w_ld_victim = r_q_victim[w_ld_ptr];

    // Only entries queued before this edge qualify; a same-edge push waits a cycle
    assign w_more_queued = (r_count > CNT_W'(1));

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_bus_valid_nxt = r_bus_valid;
        w_bus_write_nxt = r_bus_write;
        w_bus_addr_nxt  = r_bus_addr;
        w_pop           = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_load = 1'b1;
                end
            end
            S_ISSUE_WR: begin
                if (w_hs) begin
                    if (w_head_op == OP_RW) begin
                        // Write-back done; the fill of the same entry follows
                        w_state_nxt     = S_ISSUE_RD;
                        w_bus_write_nxt = 1'b0;
                        w_bus_addr_nxt  = w_head_addr;
                    end else begin
                        w_pop = 1'b1;
                        if (w_more_queued) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt     = S_IDLE;
                            w_bus_valid_nxt = 1'b0;
                        end
                    end
                end
            end
            S_ISSUE_RD: begin
                if (w_hs) begin
                    w_pop = 1'b1;
                    if (w_more_queued) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_bus_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_bus_valid_nxt = 1'b0;
            end
        endcase

        if (w_load) begin
            w_bus_valid_nxt = 1'b1;
            case (w_ld_op)
                OP_WRITE: begin
                    w_state_nxt     = S_ISSUE_WR;
                    w_bus_write_nxt = 1'b1;
                    w_bus_addr_nxt  = w_ld_addr;
                end
                OP_RW: begin
                    w_state_nxt     = S_ISSUE_WR;
                    w_bus_write_nxt = 1'b1;
                    w_bus_addr_nxt  = w_ld_victim;
                end
                default: begin
                    w_state_nxt     = S_ISSUE_RD;
                    w_bus_write_nxt = 1'b0;
                    w_bus_addr_nxt  = w_ld_addr;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus outputs; an un-handshaken beat is simply dropped on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_valid <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
        end else begin
            r_bus_valid <= w_bus_valid_nxt;
            r_bus_write <= w_bus_write_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue storage needs no reset; occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wr_ptr]     <= in_op;
            r_q_addr[r_wr_ptr]   <= in_addr;
            r_q_victim[r_wr_ptr] <= in_victim_addr;
        end
    end

    // Beat statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_hs) begin
            if (r_bus_write) begin
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_rd_count <= r_rd_count + 32'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign bus_valid = r_bus_valid;
    assign bus_write = r_bus_write;
    assign bus_addr  = r_bus_addr;
    assign busy      = (r_count != '0) || (r_state != S_IDLE);
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;

endmodule

// File: doc/cache_bus_req_queue.md
# cache_bus_req_queue

Downstream stage of the L1 cache controller. Consumes the controller's per-access bus action (output_t: READ_OUT, WRITE_OUT, RW_OUT, NOP) and turns it into an ordered stream of single-beat next-level bus transactions over a valid/ready handshake. Buffers up to DEPTH actions so the controller is not stalled by a slow bus. Expands RW_OUT into a write-back beat followed by a line-fill beat. Keeps running read/write transaction counts for the end-of-run statistics report.

## Interface
Parameters:
- ADDR_W, 32, line address width
- DEPTH, 4, action queue entries; power of two, ≥2

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  controller presents an action
- in_ready  out  1  queue can accept; equals (count < DEPTH)
- in_op  in  2  output_t encoding: READ_OUT=0, WRITE_OUT=1, RW_OUT=2, NOP=3
- in_addr  in  ADDR_W  address of the accessed line
- in_victim_addr  in  ADDR_W  address of the evicted dirty line; used only by RW_OUT
- bus_valid  out  1  bus beat presented
- bus_ready  in  1  bus accepts beat
- bus_write  out  1  1 = write-back beat, 0 = read/fill beat
- bus_addr  out  ADDR_W  beat address
- busy  out  1  queue non-empty or beat in flight
- rd_count  out  32  accepted read beats
- wr_count  out  32  accepted write beats

## Operation
- Accept: when in_valid && in_ready at a rising edge.
  - READ_OUT, WRITE_OUT and RW_OUT push {op, addr, victim} into a circular FIFO.
  - NOP is consumed and discarded. It needs in_ready like any other op and never changes count.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD.
- IDLE, queue non-empty: load the head entry.
  - READ_OUT → ISSUE_RD, bus_addr = addr.
  - WRITE_OUT → ISSUE_WR, bus_addr = addr.
  - RW_OUT → ISSUE_WR, bus_addr = victim.
- ISSUE_WR, handshake:
  - If the head is RW_OUT → ISSUE_RD, bus_addr = head addr, bus_write = 0, entry kept.
  - Otherwise pop the entry. Load the next entry if one was present before this edge; else go to IDLE.
- ISSUE_RD, handshake: pop the entry. Load the next entry or go to IDLE, same rule as above.
- While bus_valid is high without bus_ready, bus_addr and bus_write hold stable.
- Counters:
  - wr_count increments on each write-beat handshake; rd_count on each read-beat handshake.
  - Both wrap modulo 2^32.
- busy = (count != 0) || (state != IDLE).
- Simultaneous push and pop in one edge: count unchanged; both pointers advance; both pointers wrap at DEPTH.

## Timing
- Reset, applied at any time including mid-beat:
  - Next edge: state = IDLE, queue emptied, bus_valid = 0, bus_write = 0, bus_addr = 0, rd_count = wr_count = 0, busy = 0, in_ready = 1.
  - An un-handshaken beat is dropped and not counted.
- All bus outputs are registered.
- Latency: an action accepted at edge k into an empty, IDLE queue gives bus_valid high from edge k+1.
- An entry pushed at the same edge the queue drains to empty is issued one cycle later (one IDLE bubble). There is no bypass.
- Throughput:
  - Back-to-back beats with no bubble when the next entry was already queued.
  - RW_OUT occupies two consecutive beats.
- Full: in_ready is 0 while count == DEPTH. A pop in that cycle raises in_ready only from the following cycle.
- Order: beats leave in acceptance order. The write-back of an RW_OUT always precedes its fill.

## Test plan
- Reset, then READ_OUT addr 0x100 with bus_ready held 1 → bus_valid one edge after acceptance; one beat, bus_write = 0, bus_addr 0x100; rd_count = 1, wr_count = 0; busy drops after the handshake.
- RW_OUT addr 0x200, victim 0x3C0, with bus_ready = 0 for 3 cycles → beat {write, 0x3C0} stable for 3 cycles, then {read, 0x200}; counts wr = 1, rd = 1.
- With bus_ready = 0, push 4 READ_OUTs (0x10, 0x20, 0x30, 0x40) plus NOP attempts → in_ready = 0 after the 4th push; NOP not accepted while full; release bus_ready → beats in order with no gaps; rd_count = 4.
- Interleave NOPs with a WRITE_OUT to 0x55 → NOPs produce no beats; exactly one write beat to 0x55; wr_count = 1.
- Assert rst while RW_OUT is mid-write with 2 more entries queued → next edge: bus_valid = 0, counts 0, busy = 0; a READ_OUT 0x80 pushed afterwards issues normally.
- Push 2·DEPTH+1 mixed actions with bus_ready randomly toggled → pointer wrap is correct and beat order matches a scoreboard; final counts match the expected beat totals.
